seq_divider: RTL and testbench

//  Multi-cycle radix-2 restoring integer divider. It is the responder side of the

---
 rtl/seq_divider.sv | 199 +++++++++++++++++++
 tb/tb_seq_divider.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//
// Multi-cycle radix-2 restoring integer divider serving the start/ok divider
// handshake of the IDIV function unit. Handles signed and unsigned division
// (DIV/DIVU/REM/REMU). One operation is in flight at a time.
//
// Ports
//   clock      in   1      clock, all state updates on posedge
//   reset      in   1      synchronous, active-high
//   start      in   1      request, accepted only while ok=1
//   is_signed  in   1      1: two's-complement operands, 0: unsigned
//   A          in   WIDTH  dividend, sampled at the accept edge
//   B          in   WIDTH  divisor, sampled at the accept edge
//   D          out  WIDTH  quotient of the last completed operation
//   R          out  WIDTH  remainder of the last completed operation
//   ok         out  1      idle, a start will be accepted
//   done       out  1      one-cycle pulse, D/R/err just updated
//   err        out  1      last completed operation divided by zero
//
// Parameters
//   WIDTH      operand/result width
//   FASTPATH   1: divide-by-zero and MIN/-1 complete one cycle after accept
// ---------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH    = 32,
    parameter bit FASTPATH = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] R,
    output logic             ok,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] rem;
    logic             q_neg;
    logic             r_neg;
    logic             div_zero;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic             overflow;
    logic [WIDTH:0]   rem_shift;
    logic             step_ge;
    logic [WIDTH-1:0] rem_next;

    // Operand decode at the accept edge. Magnitudes are modulo 2^WIDTH, so
    // |MIN| comes out as the unsigned value 2^(WIDTH-1), which is exactly
    // what the unsigned iteration needs.
    always_comb begin
        a_mag    = (is_signed && A[WIDTH-1]) ? -A : A;
        b_mag    = (is_signed && B[WIDTH-1]) ? -B : B;
        b_zero   = (B == '0);
        overflow = is_signed && (A == MIN_VAL) && (B == ALL_ONES);
    end

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract when it fits. The compare is done at WIDTH+1
    // bits; after a successful subtract or a failed compare the result always
    // fits back in WIDTH bits (with a zero divisor the remainder only ever
    // collects dividend bits, so it stays within WIDTH bits as well).
    always_comb begin
        rem_shift = {rem, quo[WIDTH-1]};
        step_ge   = (rem_shift >= {1'b0, divisor});
        rem_next  = step_ge ? WIDTH'(rem_shift - {1'b0, divisor})
                            : rem_shift[WIDTH-1:0];
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Special operands skip the iteration entirely when
    // FASTPATH is set; otherwise they run the full loop like any other.
    always_comb begin
        state_next = state;
        ok         = 1'b0;
        case (state)
            IDLE: begin
                ok = 1'b1;
                if (start) begin
                    if (FASTPATH && (b_zero || overflow)) begin
                        state_next = FINISH;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                if (count == LAST_ITER) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath. quo starts out holding the dividend magnitude and shifts
    // quotient bits in from the bottom as dividend bits leave the top.
    // A zero divisor iterates on the raw dividend with no sign fix-up, which
    // yields an all-ones quotient and the original dividend as remainder;
    // the fast path simply loads that answer directly.
    always_ff @(posedge clock) begin
        if (reset) begin
            count    <= '0;
            quo      <= '0;
            divisor  <= '0;
            rem      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            div_zero <= 1'b0;
            D        <= '0;
            R        <= '0;
            err      <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        count    <= '0;
                        rem      <= '0;
                        div_zero <= b_zero;
                        if (b_zero) begin
                            divisor <= '0;
                            q_neg   <= 1'b0;
                            r_neg   <= 1'b0;
                            if (FASTPATH) begin
                                quo <= ALL_ONES;
                                rem <= A;
                            end else begin
                                quo <= A;
                            end
                        end else if (FASTPATH && overflow) begin
                            divisor <= b_mag;
                            quo     <= MIN_VAL;
                            q_neg   <= 1'b0;
                            r_neg   <= 1'b0;
                        end else begin
                            quo     <= a_mag;
                            divisor <= b_mag;
                            q_neg   <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                            r_neg   <= is_signed & A[WIDTH-1];
                        end
                    end
                end
                RUN: begin
                    rem   <= rem_next;
                    quo   <= {quo[WIDTH-2:0], step_ge};
                    count <= count + 1'b1;
                end
                FINISH: begin
                    D    <= q_neg ? -quo : quo;
                    R    <= r_neg ? -rem : rem;
                    err  <= div_zero;
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//
// Drives two dividers (fast path on and off) with directed and random
// operations and compares against plain-arithmetic reference results.
// ---------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 32;
    localparam logic [W-1:0] MINV = 32'h8000_0000;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         start2 = 1'b0;
    logic         isSigned = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;

    logic [W-1:0] D, R, D2, R2;
    logic         ok, done, err, ok2, done2, err2;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W), .FASTPATH(1'b1)) dut (
        .clock(clock), .reset(reset), .start(start), .is_signed(isSigned),
        .A(A), .B(B), .D(D), .R(R), .ok(ok), .done(done), .err(err)
    );

    seq_divider #(.WIDTH(W), .FASTPATH(1'b0)) dutSlow (
        .clock(clock), .reset(reset), .start(start2), .is_signed(isSigned),
        .A(A), .B(B), .D(D2), .R(R2), .ok(ok2), .done(done2), .err(err2)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference results straight from integer arithmetic in 64 bits.
    function automatic void refModel(input logic sgn, input logic [W-1:0] a,
                                     input logic [W-1:0] b, output logic [W-1:0] q,
                                     output logic [W-1:0] r, output logic e);
        longint sa, sb;
        if (b == '0) begin
            q = '1;
            r = a;
            e = 1'b1;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            e  = 1'b0;
        end else begin
            q = a / b;
            r = a % b;
            e = 1'b0;
        end
    endfunction

    function automatic logic selOk(input bit slow);
        return slow ? ok2 : ok;
    endfunction

    function automatic logic selDone(input bit slow);
        return slow ? done2 : done;
    endfunction

    task automatic driveStart(input bit slow, input logic val);
        if (slow) start2 = val;
        else start = val;
    endtask

    // Issue one operation, follow it to completion and check everything.
    task automatic applyStimulus(input bit slow, input logic sgn, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit junkStart);
        logic [W-1:0] expQ, expR;
        logic         expE;
        int           latency, cycles, okLow, waitCount;
        refModel(sgn, a, b, expQ, expR, expE);
        latency = (!slow && (b == '0 || (sgn && a == MINV && b == '1))) ? 1 : W + 1;

        waitCount = 0;
        @(negedge clock);
        while (!selOk(slow) && waitCount < 200) begin
            @(negedge clock);
            waitCount++;
        end
        checkOutput("okBeforeStart", W'(selOk(slow)), 1);

        isSigned = sgn;
        A = a;
        B = b;
        driveStart(slow, 1'b1);
        @(posedge clock);
        #1;
        driveStart(slow, 1'b0);
        A = $urandom;
        B = $urandom;
        isSigned = 1'($urandom);
        checkOutput("donePulseEnded", W'(selDone(slow)), 0);

        okLow  = selOk(slow) ? 0 : 1;
        cycles = 0;
        while (cycles < 100) begin
            @(posedge clock);
            #1;
            cycles++;
            if (selDone(slow)) break;
            if (!selOk(slow)) okLow++;
            driveStart(slow, junkStart && (cycles == 5));
            A = $urandom;
            B = $urandom;
        end
        driveStart(slow, 1'b0);

        checkOutput("latency", W'(cycles), W'(latency));
        checkOutput("okLowCycles", W'(okLow), W'(latency));
        checkOutput("okAtDone", W'(selOk(slow)), 1);
        checkOutput("quotient", slow ? D2 : D, expQ);
        checkOutput("remainder", slow ? R2 : R, expR);
        checkOutput("err", W'(slow ? err2 : err), W'(expE));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        bit           rslow;
        int           doneSeen;

        repeat (3) @(posedge clock);
        #1;
        checkOutput("resetOk", W'(ok), 1);
        checkOutput("resetD", D, 0);
        checkOutput("resetR", R, 0);
        checkOutput("resetErr", W'(err), 0);
        checkOutput("resetDone", W'(done), 0);
        reset = 1'b0;

        // Directed cases on the fast-path divider, issued back to back.
        applyStimulus(1'b0, 1'b0, 32'd100, 32'd7, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h1234_5678, 32'd0, 1'b0);
        applyStimulus(1'b0, 1'b1, MINV, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'd1000, 32'd3, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'd55, 32'hFFFF_FFFB, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFC9, 32'hFFFF_FFFA, 1'b1);

        // Special operands without the fast path take full latency.
        applyStimulus(1'b1, 1'b1, 32'h1234_5678, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h8765_4321, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, MINV, 32'hFFFF_FFFF, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);

        // Random mix with a bias toward boundary operands.
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = MINV; rb = '1; rs = 1'b1; end
                2: rb = W'($urandom_range(1, 9));
                3: rb = {{(W-4){rb[3]}}, rb[3:0]};
                default: ;
            endcase
            rslow = ($urandom_range(0, 4) == 0);
            applyStimulus(rslow, rs, ra, rb, 1'($urandom));
        end

        // Leave non-zero results and err=1 behind, then reset mid-operation.
        applyStimulus(1'b0, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd1234, 32'd10, 1'b0);
        @(negedge clock);
        A = 32'd100;
        B = 32'd7;
        isSigned = 1'b0;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("abortOk", W'(ok), 1);
        checkOutput("abortD", D, 0);
        checkOutput("abortR", R, 0);
        checkOutput("abortErr", W'(err), 0);
        checkOutput("abortDone", W'(done), 0);
        checkOutput("abortSlowD", D2, 0);
        reset = 1'b0;
        doneSeen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (done) doneSeen++;
        end
        checkOutput("noDoneAfterAbort", W'(doneSeen), 0);

        applyStimulus(1'b0, 1'b0, 32'd100, 32'd7, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
